// File: rtl/ids_sample_loader.sv
// Stream front end for the PCA intrusion detector: assembles PC_NUM feature words
// into a vector, waits the detector settling time and returns its decision.
module ids_sample_loader #(
  parameter int PC_NUM      = 32,
  parameter int FP_SIZE     = 64,
  parameter int DET_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FP_SIZE-1:0] s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [FP_SIZE-1:0] samples_out [0:PC_NUM-1],
  output logic               vec_valid,
  input  logic               det_in,
  output logic               r_flag,
  output logic               r_valid,
  input  logic               r_ready,
  output logic               frame_err,
  output logic [CNT_W-1:0]   sample_count
);

  localparam int IDX_W = (PC_NUM > 1) ? $clog2(PC_NUM) : 1;
  localparam int LAT_W = (DET_LATENCY > 1) ? $clog2(DET_LATENCY) : 1;

  typedef enum logic [1:0] {ST_FILL, ST_DRAIN, ST_WAIT, ST_RESULT} state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [IDX_W-1:0]   idx_r;
  logic [LAT_W-1:0]   lat_cnt_r;
  logic               accept_s;
  logic               last_idx_s;

  assign accept_s   = s_valid & s_ready;
  assign last_idx_s = (idx_r == IDX_W'(PC_NUM - 1));

  // next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (accept_s && last_idx_s) begin
          next_state_s = s_last ? ST_WAIT : ST_DRAIN;
        end else begin
          next_state_s = ST_FILL;
        end
      end
      ST_DRAIN: begin
        if (accept_s && s_last) begin
          next_state_s = ST_FILL;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_r == LAT_W'(0)) begin
          next_state_s = ST_RESULT;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESULT: begin
        if (r_valid && r_ready) begin
          next_state_s = ST_FILL;
        end else begin
          next_state_s = ST_RESULT;
        end
      end
      default: next_state_s = ST_FILL;
    endcase
  end

  // state register; s_ready is registered from the next state so it is glitch-free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_FILL;
      s_ready <= 1'b1;
    end else begin
      state_r <= next_state_s;
      s_ready <= (next_state_s == ST_FILL) || (next_state_s == ST_DRAIN);
    end
  end

  // datapath: vector assembly, latency counter, result and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_r        <= IDX_W'(0);
      lat_cnt_r    <= LAT_W'(0);
      vec_valid    <= 1'b0;
      r_flag       <= 1'b0;
      r_valid      <= 1'b0;
      frame_err    <= 1'b0;
      sample_count <= CNT_W'(0);
      for (int i = 0; i < PC_NUM; i++) begin
        samples_out[i] <= {FP_SIZE{1'b0}};
      end
    end else begin
      frame_err <= 1'b0;
      case (state_r)
        ST_FILL: begin
          if (accept_s) begin
            samples_out[idx_r] <= s_data;
            if (last_idx_s) begin
              idx_r <= IDX_W'(0);
              if (s_last) begin
                vec_valid <= 1'b1;
                lat_cnt_r <= LAT_W'(DET_LATENCY - 1);
              end else begin
                frame_err <= 1'b1;
              end
            end else if (s_last) begin
              idx_r     <= IDX_W'(0);
              frame_err <= 1'b1;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end else begin
            idx_r <= idx_r;
          end
        end
        ST_WAIT: begin
          if (lat_cnt_r == LAT_W'(0)) begin
            r_flag  <= det_in;
            r_valid <= 1'b1;
          end else begin
            lat_cnt_r <= lat_cnt_r - LAT_W'(1);
          end
        end
        ST_RESULT: begin
          if (r_valid && r_ready) begin
            r_valid   <= 1'b0;
            vec_valid <= 1'b0;
            idx_r     <= IDX_W'(0);
            if (sample_count != {CNT_W{1'b1}}) begin
              sample_count <= sample_count + CNT_W'(1);
            end else begin
              sample_count <= sample_count;
            end
          end else begin
            r_valid <= r_valid;
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ids_sample_loader.sv
// Directed bench for ids_sample_loader: stimulus pushes expected results into a
// scoreboard, a negedge monitor checks every delivered result against it.
module tb_ids_sample_loader;

  localparam int PC_NUM = 32;
  localparam int FP_SIZE = 64;
  localparam int DET_LATENCY = 2;
  localparam int CNT_W = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [FP_SIZE-1:0] s_data;
  logic               s_valid;
  logic               s_last;
  logic               s_ready;
  logic [FP_SIZE-1:0] samples_out [0:PC_NUM-1];
  logic               vec_valid;
  logic               det_in;
  logic               r_flag;
  logic               r_valid;
  logic               r_ready;
  logic               frame_err;
  logic [CNT_W-1:0]   sample_count;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  logic prev_err = 1'b0;

  logic        exp_flag_q [$];
  logic [63:0] exp_base_q [$];

  ids_sample_loader #(
    .PC_NUM(PC_NUM), .FP_SIZE(FP_SIZE), .DET_LATENCY(DET_LATENCY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .samples_out(samples_out), .vec_valid(vec_valid),
    .det_in(det_in), .r_flag(r_flag), .r_valid(r_valid), .r_ready(r_ready),
    .frame_err(frame_err), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: a result handshake happens at the next rising edge
  always @(negedge clk) begin
    if (!reset && r_valid && r_ready) begin
      if (exp_flag_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got r_flag %0b expected no result", r_flag);
      end else begin
        logic        ef;
        logic [63:0] eb;
        int          bad;
        ef = exp_flag_q.pop_front();
        eb = exp_base_q.pop_front();
        check("r_flag", {63'd0, r_flag}, {63'd0, ef});
        bad = -1;
        for (int i = 0; i < PC_NUM; i++) begin
          if (bad < 0 && samples_out[i] !== eb + 64'(i)) bad = i;
        end
        if (bad < 0) begin
          check("samples_out", 64'd0, 64'd0 + samples_out[0] - eb);
        end else begin
          check("samples_out", samples_out[bad], eb + 64'(bad));
        end
      end
    end
  end

  // frame_err pulse counter and single-cycle check
  always @(negedge clk) begin
    if (frame_err) begin
      err_pulses++;
      check("frame_err_width", {63'd0, prev_err}, 64'd0);
    end
    prev_err <= frame_err;
  end

  task automatic send_word(input logic [63:0] d, input logic last);
    int n;
    n = 0;
    s_data = d; s_last = last; s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got s_ready 0 expected 1");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at, input logic [63:0] base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) @(posedge clk);
        #1;
      end
      send_word(base + 64'(i), (i == last_at));
    end
  endtask

  task automatic wait_rvalid();
    int n;
    n = 0;
    while (!r_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!r_valid) begin
      checks++; errors++;
      $display("FAIL result_timeout: got r_valid 0 expected 1");
    end
  endtask

  task automatic take_result();
    wait_rvalid();
    r_ready = 1'b1;
    @(posedge clk);
    #1;
    r_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    logic [63:0] s7;
    reset = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; det_in = 1'b0; r_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec_valid", {63'd0, vec_valid}, 64'd0);
    check("rst_r_valid", {63'd0, r_valid}, 64'd0);
    check("rst_frame_err", {63'd0, frame_err}, 64'd0);
    check("rst_count", 64'(sample_count), 64'd0);
    check("rst_samples", samples_out[5], 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_s_ready", {63'd0, s_ready}, 64'd1);

    // nominal frame, detailed latency check
    det_in = 1'b1;
    exp_flag_q.push_back(1'b1); exp_base_q.push_back(64'd0);
    send_frame(32, 31, 64'd0, 1'b0);
    check("nom_vec_valid", {63'd0, vec_valid}, 64'd1);
    check("nom_s_ready_wait", {63'd0, s_ready}, 64'd0);
    check("nom_r_valid_N", {63'd0, r_valid}, 64'd0);
    @(posedge clk); #1;
    check("nom_r_valid_N1", {63'd0, r_valid}, 64'd0);
    @(posedge clk); #1;
    check("nom_r_valid_N2", {63'd0, r_valid}, 64'd1);
    check("nom_r_flag", {63'd0, r_flag}, 64'd1);
    take_result();
    check("nom_count", 64'(sample_count), 64'd1);
    check("nom_s_ready_after", {63'd0, s_ready}, 64'd1);
    check("nom_vec_valid_after", {63'd0, vec_valid}, 64'd0);

    // backpressure
    det_in = 1'b1;
    exp_flag_q.push_back(1'b1); exp_base_q.push_back(64'hA000);
    send_frame(32, 31, 64'hA000, 1'b0);
    wait_rvalid();
    s7 = samples_out[7];
    for (int c = 0; c < 10; c++) begin
      s_valid = 1'b1; s_data = 64'hDEAD; det_in = ~det_in;
      @(posedge clk); #1;
      check("bp_r_valid", {63'd0, r_valid}, 64'd1);
      check("bp_r_flag", {63'd0, r_flag}, 64'd1);
      check("bp_s_ready", {63'd0, s_ready}, 64'd0);
      check("bp_samples", samples_out[7], 64'hA007);
    end
    check("bp_samples_stable", samples_out[7], s7);
    s_valid = 1'b0; det_in = 1'b1;
    take_result();
    check("bp_s_ready_after", {63'd0, s_ready}, 64'd1);
    check("bp_count", 64'(sample_count), 64'd2);

    // short frame then good frame with det_in=0
    det_in = 1'b0;
    e0 = err_pulses;
    send_frame(6, 5, 64'hB000, 1'b0);
    check("short_err_on", {63'd0, frame_err}, 64'd1);
    @(posedge clk); #1;
    check("short_err_off", {63'd0, frame_err}, 64'd0);
    check("short_r_valid", {63'd0, r_valid}, 64'd0);
    check("short_vec_valid", {63'd0, vec_valid}, 64'd0);
    check("short_pulses", 64'(err_pulses - e0), 64'd1);
    exp_flag_q.push_back(1'b0); exp_base_q.push_back(64'hC000);
    send_frame(32, 31, 64'hC000, 1'b0);
    take_result();
    check("short_next_count", 64'(sample_count), 64'd3);

    // long frame: 35 words, error at 32nd, drain remainder
    e0 = err_pulses;
    send_frame(32, -1, 64'hD000, 1'b0);
    check("long_err_on", {63'd0, frame_err}, 64'd1);
    check("long_s_ready", {63'd0, s_ready}, 64'd1);
    send_frame(3, 2, 64'hD020, 1'b0);
    check("long_s_ready_end", {63'd0, s_ready}, 64'd1);
    repeat (4) @(posedge clk); #1;
    check("long_r_valid", {63'd0, r_valid}, 64'd0);
    check("long_vec_valid", {63'd0, vec_valid}, 64'd0);
    check("long_pulses", 64'(err_pulses - e0), 64'd1);
    det_in = 1'b1;
    exp_flag_q.push_back(1'b1); exp_base_q.push_back(64'hE000);
    send_frame(32, 31, 64'hE000, 1'b0);
    take_result();
    check("sat_count_4", 64'(sample_count), 64'd3);

    // frame with random gaps
    det_in = 1'b0;
    exp_flag_q.push_back(1'b0); exp_base_q.push_back(64'hF000);
    send_frame(32, 31, 64'hF000, 1'b1);
    take_result();
    check("sat_count_5", 64'(sample_count), 64'd3);

    // reset mid-WAIT
    det_in = 1'b1;
    send_frame(32, 31, 64'h1000, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rw_vec_valid", {63'd0, vec_valid}, 64'd0);
    check("rw_r_valid", {63'd0, r_valid}, 64'd0);
    check("rw_r_flag", {63'd0, r_flag}, 64'd0);
    check("rw_count", 64'(sample_count), 64'd0);
    check("rw_samples", samples_out[3], 64'd0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rw_s_ready", {63'd0, s_ready}, 64'd1);
    repeat (6) @(posedge clk); #1;
    check("rw_no_result", {63'd0, r_valid}, 64'd0);
    check("sb_empty", 64'(exp_flag_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
